// File: rtl/instr_encoder.sv
// instr_encoder: turns compact operation commands into RV32I instruction words on a valid/ready output.
// Optional build macro INSTR_ENCODER_LI_EN adds the LI pseudo-op (LUI + ADDI expansion) and its hold register.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [3:0]  cmd_funct,
    input  logic [31:0] cmd_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [15:0] issued
);

    // state | meaning
    // IDLE  | no word held, a command can be taken
    // EMIT  | instr holds a word waiting for its handshake
    // EMIT2 | instr holds the second word of an LI expansion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1
`ifdef INSTR_ENCODER_LI_EN
        , EMIT2 = 2'd2
`endif
    } state_t;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;

    state_t      state;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        accept;
    logic        handshake;
    logic        load_new;

`ifdef INSTR_ENCODER_LI_EN
    logic        pending2;
    logic [31:0] hold;
    logic [31:0] enc_word2;
    logic        enc_two;
    logic [11:0] li_lo;
    logic [19:0] li_hi;
    logic        li_small;

    assign li_lo    = cmd_imm[11:0];
    // rounding up compensates for ADDI sign-extending the low 12 bits
    assign li_hi    = cmd_imm[31:12] + {19'd0, cmd_imm[11]};
    assign li_small = (&cmd_imm[31:11]) || (~|cmd_imm[31:11]);

    assign cmd_ready = (state == IDLE) || ((state == EMIT) && instr_ready && !pending2);
`else
    assign cmd_ready = (state == IDLE) || ((state == EMIT) && instr_ready);
`endif

    assign f3        = cmd_funct[2:0];
    assign f7        = {1'b0, cmd_funct[3], 5'b0};
    assign accept    = cmd_valid && cmd_ready;
    assign handshake = instr_valid && instr_ready;
    assign load_new  = accept && !enc_illegal;

    always_comb begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b0;
`ifdef INSTR_ENCODER_LI_EN
        enc_word2   = NOP_WORD;
        enc_two     = 1'b0;
`endif
        case (cmd_op)
            4'd0: enc_word = NOP_WORD;
            4'd1: enc_word = {cmd_imm[31:12], cmd_rd, OPC_LUI};
            4'd2: enc_word = {cmd_imm[31:12], cmd_rd, OPC_AUIPC};
            4'd3: begin
                enc_word    = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, OPC_JAL};
                enc_illegal = cmd_imm[0];
            end
            4'd4: enc_word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, OPC_JALR};
            4'd5: begin
                enc_word    = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, f3,
                               cmd_imm[4:1], cmd_imm[11], OPC_BRANCH};
                enc_illegal = cmd_imm[0];
            end
            4'd6: enc_word = {cmd_imm[11:0], cmd_rs1, f3, cmd_rd, OPC_LOAD};
            4'd7: enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, f3, cmd_imm[4:0], OPC_STORE};
            4'd8: begin
                case (f3)
                    3'b001:  enc_word = {7'b0, cmd_imm[4:0], cmd_rs1, f3, cmd_rd, OPC_OP_IMM};
                    3'b101:  enc_word = {f7, cmd_imm[4:0], cmd_rs1, f3, cmd_rd, OPC_OP_IMM};
                    default: enc_word = {cmd_imm[11:0], cmd_rs1, f3, cmd_rd, OPC_OP_IMM};
                endcase
            end
            4'd9: enc_word = {f7, cmd_rs2, cmd_rs1, f3, cmd_rd, OPC_OP};
`ifdef INSTR_ENCODER_LI_EN
            4'd10: begin
                if (li_small) begin
                    enc_word = {li_lo, 5'd0, 3'b000, cmd_rd, OPC_OP_IMM};
                end else begin
                    enc_word = {li_hi, cmd_rd, OPC_LUI};
                    if (li_lo != 12'd0) begin
                        enc_word2 = {li_lo, cmd_rd, 3'b000, cmd_rd, OPC_OP_IMM};
                        enc_two   = 1'b1;
                    end
                end
            end
`endif
            default: enc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            instr       <= NOP_WORD;
            err         <= 1'b0;
            issued      <= 16'd0;
`ifdef INSTR_ENCODER_LI_EN
            pending2    <= 1'b0;
            hold        <= NOP_WORD;
`endif
        end else begin
            err <= accept && enc_illegal;
            if (handshake) begin
                issued <= issued + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (load_new) begin
                        instr       <= enc_word;
                        instr_valid <= 1'b1;
                        state       <= EMIT;
`ifdef INSTR_ENCODER_LI_EN
                        pending2    <= enc_two;
                        hold        <= enc_word2;
`endif
                    end
                end
                EMIT: begin
                    if (handshake) begin
`ifdef INSTR_ENCODER_LI_EN
                        if (pending2) begin
                            instr    <= hold;
                            pending2 <= 1'b0;
                            state    <= EMIT2;
                        end else
`endif
                        if (load_new) begin
                            instr       <= enc_word;
                            instr_valid <= 1'b1;
                            state       <= EMIT;
`ifdef INSTR_ENCODER_LI_EN
                            pending2    <= enc_two;
                            hold        <= enc_word2;
`endif
                        end else begin
                            instr_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
`ifdef INSTR_ENCODER_LI_EN
                EMIT2: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
